register_file_param: RTL and testbench

//   Parametrised register file: DEPTH words of WIDTH bits, one write port, two combinational read ports.
//   Per-word valid bits. A sequenced bulk-clear engine zeroes the array one word per cycle.

---
 rtl/regfile_pkg.sv | 6 +
 rtl/register_word_param.sv | 24 ++
 rtl/register_file_param.sv | 89 ++++++++
 tb/tb_register_file_param.sv | 129 ++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared clear-engine state encodings for register_file_param.
package regfile_pkg;
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] CLEAR = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;
endpackage

// File: rtl/register_word_param.sv
// register_word_param: one storage word, async active-low reset, sync clear over load.
//   clk   in  clock
//   reset in  async active-low reset
//   ld_i  in  load d_i
//   clr_i in  synchronous clear (wins over ld_i)
//   d_i   in  WIDTH load data
//   q_o   out WIDTH stored word
module register_word_param #(
   parameter int WIDTH = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ld_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   logic [WIDTH-1:0] word_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) word_q <= '0;
      else if (clr_i) word_q <= '0;
      else if (ld_i) word_q <= d_i;
   assign q_o = word_q;
endmodule

// File: rtl/register_file_param.sv
// register_file_param: DEPTH x WIDTH register file, 1 write / 2 read ports, per-word valid, bulk-clear engine.
//   clk, reset (async active-low)
//   regWrite/wrAddr/writeData   write port; dropped while clearing or when wrAddr>=DEPTH
//   rdAddrA/rdAddrB -> outA/outB, validA/validB   combinational reads, 0/invalid when unwritten or out of range
//   clrReq in, clrBusy/clrDone out   bulk clear, one word per cycle
//   wrDropped   one-cycle pulse after a discarded write
//   Optional macro REGFILE_BYPASS_EN: forward an accepted write to a same-address read in the same cycle.
module register_file_param #(
   parameter  int WIDTH  = 9,
   parameter  int DEPTH  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              regWrite,
   input  logic [ADDR_W-1:0] wrAddr,
   input  logic [WIDTH-1:0]  writeData,
   input  logic [ADDR_W-1:0] rdAddrA,
   input  logic [ADDR_W-1:0] rdAddrB,
   output logic [WIDTH-1:0]  outA,
   output logic [WIDTH-1:0]  outB,
   output logic              validA,
   output logic              validB,
   input  logic              clrReq,
   output logic              clrBusy,
   output logic              clrDone,
   output logic              wrDropped
);
   import regfile_pkg::*;
   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);
   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic [DEPTH-1:0]  valid_q, valid_d;
   logic              wr_drop_q, wr_drop_d;
   logic [WIDTH-1:0]  word_q [DEPTH];
   logic clearing, wr_acc, ok_a, ok_b, hit_a, hit_b, byp_a, byp_b;
   assign clearing = state_q == CLEAR;
   assign wr_acc   = regWrite && !clearing && ({1'b0, wrAddr} < DEPTH_C);
   for (genvar i = 0; i < DEPTH; i++) begin : g_word
      register_word_param #(.WIDTH(WIDTH)) u_word (
         .clk   (clk),
         .reset (reset),
         .ld_i  (wr_acc && wrAddr == ADDR_W'(i)),
         .clr_i (clearing && idx_q == ADDR_W'(i)),
         .d_i   (writeData),
         .q_o   (word_q[i])
      );
   end
   always_comb begin
      valid_d = valid_q;
      if (wr_acc) valid_d[wrAddr] = 1'b1;
      if (clearing) valid_d[idx_q] = 1'b0;
      state_d   = state_q == IDLE ? (clrReq ? CLEAR : IDLE) : clearing ? (idx_q == LAST ? DONE : CLEAR) : IDLE;
      idx_d     = (clearing && idx_q != LAST) ? idx_q + 1'b1 : '0;
      wr_drop_d = regWrite && !wr_acc;
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         valid_q   <= '0;
         wr_drop_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         valid_q   <= valid_d;
         wr_drop_q <= wr_drop_d;
      end
`ifdef REGFILE_BYPASS_EN
   assign byp_a = wr_acc && rdAddrA == wrAddr;
   assign byp_b = wr_acc && rdAddrB == wrAddr;
`else
   assign byp_a = 1'b0;
   assign byp_b = 1'b0;
`endif
   // Range check first so an out-of-range address never selects a stale valid bit.
   assign ok_a      = {1'b0, rdAddrA} < DEPTH_C;
   assign ok_b      = {1'b0, rdAddrB} < DEPTH_C;
   assign hit_a     = ok_a && valid_q[rdAddrA];
   assign hit_b     = ok_b && valid_q[rdAddrB];
   assign validA    = byp_a || hit_a;
   assign validB    = byp_b || hit_b;
   assign outA      = byp_a ? writeData : hit_a ? word_q[rdAddrA] : '0;
   assign outB      = byp_b ? writeData : hit_b ? word_q[rdAddrB] : '0;
   assign clrBusy   = clearing;
   assign clrDone   = state_q == DONE;
   assign wrDropped = wr_drop_q;
endmodule

// File: tb/tb_register_file_param.sv
// tb_register_file_param: scoreboard bench for register_file_param (DEPTH=8 and DEPTH=6 instances).
module tb_register_file_param;
   logic clk = 1'b0, reset = 1'b0;
   always #5 clk = ~clk;
   logic       regWrite = 0, clrReq = 0;
   logic [2:0] wrAddr = 0, rdAddrA = 0, rdAddrB = 0;
   logic [8:0] writeData = 0, outA, outB;
   logic       validA, validB, clrBusy, clrDone, wrDropped;
   logic       regWrite6 = 0, clrReq6 = 0;
   logic [2:0] wrAddr6 = 0, rdAddrA6 = 0, rdAddrB6 = 0;
   logic [8:0] writeData6 = 0, outA6, outB6;
   logic       validA6, validB6, clrBusy6, clrDone6, wrDropped6;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   register_file_param dut (
      .clk(clk), .reset(reset), .regWrite(regWrite), .wrAddr(wrAddr), .writeData(writeData),
      .rdAddrA(rdAddrA), .rdAddrB(rdAddrB), .outA(outA), .outB(outB), .validA(validA), .validB(validB),
      .clrReq(clrReq), .clrBusy(clrBusy), .clrDone(clrDone), .wrDropped(wrDropped));
   register_file_param #(.WIDTH(9), .DEPTH(6)) dut6 (
      .clk(clk), .reset(reset), .regWrite(regWrite6), .wrAddr(wrAddr6), .writeData(writeData6),
      .rdAddrA(rdAddrA6), .rdAddrB(rdAddrB6), .outA(outA6), .outB(outB6), .validA(validA6), .validB(validB6),
      .clrReq(clrReq6), .clrBusy(clrBusy6), .clrDone(clrDone6), .wrDropped(wrDropped6));
   typedef struct {
      int         k;
      logic [8:0] v;
      string      n;
   } exp_t;
   exp_t sb[$];
   int n_chk = 0, n_pass = 0;
   function automatic logic [8:0] get(int k);
      case (k)
         0: return outA;
         1: return {8'd0, validA};
         2: return outB;
         3: return {8'd0, validB};
         4: return {8'd0, clrBusy};
         5: return {8'd0, clrDone};
         6: return {8'd0, wrDropped};
         7: return outA6;
         8: return {8'd0, validA6};
         default: return {8'd0, wrDropped6};
      endcase
   endfunction
   task automatic exp(input int k, input logic [8:0] v, input string n);
      sb.push_back('{k, v, n});
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   always @(negedge clk) begin : monitor
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         if (get(e.k) === e.v) n_pass++;
         else $display("FAIL %s: got %h expected %h", e.n, get(e.k), e.v);
      end
   end
   initial begin
      step();
      for (int k = 0; k < 10; k++) exp(k, 9'h0, "reset_state");
      step(); reset = 1'b1;
      step(); regWrite = 1; wrAddr = 3; writeData = 9'h1A5; rdAddrA = 3;
      exp(0, BYP ? 9'h1A5 : 9'h0, "same_cycle_a3"); exp(1, {8'd0, BYP}, "same_cycle_a3_valid");
      step(); regWrite = 0;
      exp(0, 9'h1A5, "read_a3"); exp(1, 9'h1, "read_a3_valid"); exp(6, 9'h0, "no_drop");
      step(); regWrite = 1; wrAddr = 5; writeData = 9'h0FF; rdAddrB = 5;
      exp(2, BYP ? 9'h0FF : 9'h0, "bypass_b5"); exp(3, {8'd0, BYP}, "bypass_b5_valid");
      step(); regWrite = 0;
      exp(2, 9'h0FF, "read_b5"); exp(3, 9'h1, "read_b5_valid");
      for (int i = 0; i < 8; i++) begin
         step(); regWrite = 1; wrAddr = 3'(i); writeData = 9'h100 | 9'(i);
      end
      step(); regWrite = 0; rdAddrA = 0; rdAddrB = 7; clrReq = 1;
      exp(0, 9'h100, "fill_a0"); exp(2, 9'h107, "fill_b7"); exp(4, 9'h0, "idle_not_busy");
      step(); clrReq = 0; regWrite = 1; wrAddr = 2; writeData = 9'h1FF;
      exp(4, 9'h1, "busy_1"); exp(0, 9'h100, "clear_pending_a0"); exp(1, 9'h1, "clear_pending_a0_valid");
      step(); regWrite = 0;
      exp(6, 9'h1, "drop_in_clear"); exp(4, 9'h1, "busy_2"); exp(0, 9'h0, "cleared_a0"); exp(1, 9'h0, "cleared_a0_valid");
      exp(2, 9'h107, "uncleared_b7"); exp(3, 9'h1, "uncleared_b7_valid");
      for (int c = 3; c <= 8; c++) begin
         step();
         exp(4, 9'h1, $sformatf("busy_%0d", c)); exp(5, 9'h0, "no_done_while_busy"); exp(6, 9'h0, "drop_once");
      end
      step(); exp(4, 9'h0, "busy_end"); exp(5, 9'h1, "done_pulse");
      step(); exp(4, 9'h0, "idle_after_done"); exp(5, 9'h0, "done_once");
      for (int i = 0; i < 8; i++) begin
         step(); rdAddrA = 3'(i); rdAddrB = 3'(i);
         exp(0, 9'h0, $sformatf("post_clear_a%0d", i)); exp(1, 9'h0, "post_clear_valid_a");
         exp(2, 9'h0, "post_clear_b"); exp(3, 9'h0, "post_clear_valid_b");
      end
      step(); regWrite = 1; wrAddr = 1; writeData = 9'h0AA;
      step(); wrAddr = 6; writeData = 9'h0CC;
      step(); regWrite = 0; clrReq = 1; rdAddrA = 1; rdAddrB = 6;
      exp(0, 9'h0AA, "pre_clear_a1");
      step(); clrReq = 0;
      step(); step(); step();
      exp(4, 9'h1, "busy_cycle3"); exp(0, 9'h0, "cycle3_a1"); exp(1, 9'h0, "cycle3_a1_valid");
      exp(2, 9'h0CC, "cycle3_b6"); exp(3, 9'h1, "cycle3_b6_valid");
      @(negedge clk); #1; reset = 1'b0;
      exp(4, 9'h0, "rst_busy"); exp(5, 9'h0, "rst_done"); exp(2, 9'h0, "rst_b6"); exp(3, 9'h0, "rst_b6_valid");
      step(); step(); reset = 1'b1;
      for (int c = 0; c < 10; c++) begin
         step(); exp(5, 9'h0, "no_done_after_rst"); exp(4, 9'h0, "idle_after_rst");
      end
      step(); regWrite6 = 1; wrAddr6 = 4; writeData6 = 9'h033;
      step(); wrAddr6 = 7; writeData6 = 9'h155; rdAddrA6 = 4;
      exp(7, 9'h033, "d6_a4"); exp(8, 9'h1, "d6_a4_valid"); exp(9, 9'h0, "d6_no_drop");
      step(); regWrite6 = 0; rdAddrA6 = 7;
      exp(9, 9'h1, "d6_drop_addr7"); exp(7, 9'h0, "d6_a7"); exp(8, 9'h0, "d6_a7_valid");
      step(); rdAddrA6 = 4; regWrite6 = 1; wrAddr6 = 6; writeData6 = 9'h1EE;
      exp(7, 9'h033, "d6_a4_kept"); exp(9, 9'h0, "d6_drop_once");
      step(); regWrite6 = 0; rdAddrA6 = 6;
      exp(9, 9'h1, "d6_drop_addr6"); exp(7, 9'h0, "d6_a6"); exp(8, 9'h0, "d6_a6_valid");
      step(); rdAddrA6 = 5;
      exp(7, 9'h0, "d6_a5_untouched"); exp(8, 9'h0, "d6_a5_valid");
      step(); step();
      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
         n_chk += sb.size();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
